sprite_palette_bank: RTL and testbench
======================================

Name: sprite_palette_bank

Overview:
- Runtime-writable, multi-palette colour lookup for sprite pixel streams: maps a palette select plus colour index to 12-bit RGB, with transparency-key detection.
- Sits between the sprite ROM readers and the VGA colour mux, so multiple players/states share one sprite image with different palettes.
- Palette contents are loaded and cleared at runtime via a write port and a clear FSM.
- Fixed 2-cycle read pipeline with no stall, suitable for the free-running pixel clock domain.

Parameters:
- INDEX_W, 4, colour index width; entries per palette = 2**INDEX_W
- NUM_PAL, 4, number of palettes (power of 2, >=2)
- CH_W, 4, bits per colour channel
- TRANSP_IDX, 1, index treated as transparent key in every palette

Ports:
- Clk  in  1  pixel/system clock
- Reset_n  in  1  asynchronous active-low reset
- pix_valid  in  1  qualifies pal_sel/index this cycle
- pal_sel  in  $clog2(NUM_PAL)  palette to read
- index  in  INDEX_W  colour index to read
- red, green, blue  out  CH_W each  looked-up colour
- transparent  out  1  index equalled TRANSP_IDX
- out_valid  out  1  red/green/blue/transparent valid
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid&wr_ready
- wr_pal  in  $clog2(NUM_PAL)  palette to write
- wr_idx  in  INDEX_W  entry to write
- wr_data  in  3*CH_W  {R,G,B}
- clear_req  in  1  one-cycle pulse: start zeroing all entries
- clear_busy  out  1  clear sweep in progress

Behaviour:
- Reset (Reset_n=0, async): all palette entries 0; red/green/blue=0; transparent=0; out_valid=0; pipeline valids=0; FSM=IDLE; wr_ready=1; clear_busy=0.
- Read pipeline:
  - Stage 1 registers pix_valid, pal_sel, index, and (index==TRANSP_IDX).
  - Stage 2 registers the memory word at {pal_sel,index} and drives all outputs.
  - Latency exactly 2 cycles from pix_valid to out_valid; one result per cycle, no bubbles.
  - When pix_valid was 0: out_valid=0; colour and transparent outputs hold their previous values.
- Transparency:
  - transparent=1 when the captured index==TRANSP_IDX.
  - red/green/blue then forced to 0 regardless of memory contents.
- Write port:
  - wr_ready=1 in IDLE, 0 in CLEAR.
  - Accepted write updates entry {wr_pal,wr_idx} at the clock edge.
- Read/write collision (same entry, same cycle as the stage-2 memory read): read returns the old data; new data is visible to reads sampled in later cycles.
- Clear FSM:
  - IDLE -> CLEAR on clear_req=1.
  - CLEAR walks address 0..NUM_PAL*2**INDEX_W-1, one entry per cycle, writing 0; clear_busy=1 throughout.
  - After the last address: -> IDLE, clear_busy=0, wr_ready=1 on the next cycle.
  - clear_req while in CLEAR: ignored, no restart.
  - clear_req and wr_valid in the same IDLE cycle: the clear wins and the write is not accepted (wr_ready is 0 that cycle because clear_req is decoded combinationally).
  - Reads during CLEAR are allowed; each entry returns either its old value or 0.
- Address counter: width $clog2(NUM_PAL)+INDEX_W; wraps to 0 on exit.
- Reset mid-clear: FSM returns to IDLE immediately; memory is zeroed by reset anyway.

Optional Feature:
- Macro PALETTE_FADE_EN.
- Defined:
  - Adds input fade_lvl [CH_W-1:0].
  - Stage 2 subtracts fade_lvl from each channel with saturation at 0, e.g. channel 4'h3, fade 4'h5 -> 4'h0.
  - fade_lvl is sampled in stage 1; latency stays 2.
  - Transparent pixels stay 0.
- Undefined: no fade_lvl port; channels pass unmodified.

Test Plan:
- Reset, then read pal 0 idx 5 -> out_valid high 2 cycles after pix_valid; RGB=000, transparent=0.
- Write pal 2 idx 3 = 12'hE43, then read pal 2 idx 3 -> RGB = E,4,3. Read pal 1 idx 3 -> 000.
- Write pal 0 idx 1 = 12'hF0F, read pal 0 idx 1 -> transparent=1, RGB=000.
- Stream 16 back-to-back reads, one per cycle -> 16 consecutive out_valid results in order, no gaps.
- Load pal 3 idx 15 = 12'hDED; pulse clear_req with wr_valid=1 -> write not accepted.
  - clear_busy high for 64 cycles (defaults); wr_ready low throughout.
  - Afterwards pal 3 idx 15 reads 000.
- Collision: read and write pal 1 idx 7 (old 12'h16A, new 12'h8DA) in the same cycle -> result 16A; a read issued next cycle -> 8DA.
- With PALETTE_FADE_EN: entry 12'h4A8, fade_lvl=5 -> RGB = 0,5,3.

Source files
------------

// File: rtl/sprite_palette_bank_if.sv
// Pixel-read, palette-write and clear-control bundle for sprite_palette_bank.
// The fade_lvl signal exists only when PALETTE_FADE_EN is defined.
interface sprite_palette_bank_if #(
    parameter int INDEX_W = 4,
    parameter int NUM_PAL = 4,
    parameter int CH_W    = 4
);
    localparam int PAL_W = $clog2(NUM_PAL);

    logic               pix_valid;
    logic [PAL_W-1:0]   pal_sel;
    logic [INDEX_W-1:0] index;
    logic [CH_W-1:0]    red;
    logic [CH_W-1:0]    green;
    logic [CH_W-1:0]    blue;
    logic               transparent;
    logic               out_valid;
    logic               wr_valid;
    logic               wr_ready;
    logic [PAL_W-1:0]   wr_pal;
    logic [INDEX_W-1:0] wr_idx;
    logic [3*CH_W-1:0]  wr_data;
    logic               clear_req;
    logic               clear_busy;
`ifdef PALETTE_FADE_EN
    logic [CH_W-1:0]    fade_lvl;
`endif

    modport master (
`ifdef PALETTE_FADE_EN
        output fade_lvl,
`endif
        output pix_valid, pal_sel, index, wr_valid, wr_pal, wr_idx, wr_data, clear_req,
        input  red, green, blue, transparent, out_valid, wr_ready, clear_busy
    );

    modport slave (
`ifdef PALETTE_FADE_EN
        input  fade_lvl,
`endif
        input  pix_valid, pal_sel, index, wr_valid, wr_pal, wr_idx, wr_data, clear_req,
        output red, green, blue, transparent, out_valid, wr_ready, clear_busy
    );
endinterface

// File: rtl/sprite_palette_bank.sv
// Multi-palette sprite colour lookup: 2-stage read pipeline, write port, clear sweep.
// Optional PALETTE_FADE_EN adds a saturating per-channel fade in stage 2.
module sprite_palette_bank #(
    parameter int INDEX_W    = 4,
    parameter int NUM_PAL    = 4,
    parameter int CH_W       = 4,
    parameter int TRANSP_IDX = 1
) (
    input logic clk,
    input logic rst_n,
    sprite_palette_bank_if.slave bus
);
    localparam int PAL_W  = $clog2(NUM_PAL);
    localparam int ADDR_W = PAL_W + INDEX_W;
    localparam int DEPTH  = NUM_PAL * (2 ** INDEX_W);
    localparam int WORD_W = 3 * CH_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  clr_addr_reg, clr_addr_next;
    logic               wr_ready_c;
    logic               clear_busy_c;
    logic               wr_fire;
    logic [ADDR_W-1:0]  wr_addr;

    logic [WORD_W-1:0]  mem_reg [DEPTH];

    logic               valid_s1_reg;
    logic [ADDR_W-1:0]  addr_s1_reg;
    logic               transp_s1_reg;
`ifdef PALETTE_FADE_EN
    logic [CH_W-1:0]    fade_s1_reg;
`endif

    logic [CH_W-1:0]    red_reg, green_reg, blue_reg;
    logic               transparent_reg;
    logic               out_valid_reg;
    logic [WORD_W-1:0]  rd_word;
    logic [CH_W-1:0]    red_next, green_next, blue_next;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        wr_ready_c    = 1'b0;
        clear_busy_c  = 1'b0;
        case (state_reg)
            IDLE: begin
                // A clear request in the same cycle pre-empts any write.
                wr_ready_c = ~bus.clear_req;
                if (bus.clear_req) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            CLEAR: begin
                clear_busy_c  = 1'b1;
                clr_addr_next = clr_addr_reg + 1'b1;
                if (clr_addr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_fire        = bus.wr_valid & wr_ready_c;
    assign wr_addr        = {bus.wr_pal, bus.wr_idx};
    assign bus.wr_ready   = wr_ready_c;
    assign bus.clear_busy = clear_busy_c;

    // ---------------- palette storage ----------------
    // Per-entry registers so the whole store clears on reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (clear_busy_c && (clr_addr_reg == ADDR_W'(gi))) begin
                    mem_reg[gi] <= '0;
                end else if (wr_fire && (wr_addr == ADDR_W'(gi))) begin
                    mem_reg[gi] <= bus.wr_data;
                end
            end
        end
    endgenerate

    // ---------------- stage 1 ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1_reg  <= 1'b0;
            addr_s1_reg   <= '0;
            transp_s1_reg <= 1'b0;
`ifdef PALETTE_FADE_EN
            fade_s1_reg   <= '0;
`endif
        end else begin
            valid_s1_reg <= bus.pix_valid;
            if (bus.pix_valid) begin
                addr_s1_reg   <= {bus.pal_sel, bus.index};
                transp_s1_reg <= (bus.index == INDEX_W'(TRANSP_IDX));
`ifdef PALETTE_FADE_EN
                fade_s1_reg   <= bus.fade_lvl;
`endif
            end
        end
    end

    // ---------------- stage 2 ----------------
    // Memory is read before this edge's write lands, so a colliding write is seen next cycle.
    assign rd_word = mem_reg[addr_s1_reg];

`ifdef PALETTE_FADE_EN
    function automatic logic [CH_W-1:0] sat_sub(input logic [CH_W-1:0] c, input logic [CH_W-1:0] f);
        return (c > f) ? (c - f) : '0;
    endfunction

    assign red_next   = sat_sub(rd_word[3*CH_W-1:2*CH_W], fade_s1_reg);
    assign green_next = sat_sub(rd_word[2*CH_W-1:CH_W],   fade_s1_reg);
    assign blue_next  = sat_sub(rd_word[CH_W-1:0],        fade_s1_reg);
`else
    assign red_next   = rd_word[3*CH_W-1:2*CH_W];
    assign green_next = rd_word[2*CH_W-1:CH_W];
    assign blue_next  = rd_word[CH_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_reg         <= '0;
            green_reg       <= '0;
            blue_reg        <= '0;
            transparent_reg <= 1'b0;
            out_valid_reg   <= 1'b0;
        end else begin
            out_valid_reg <= valid_s1_reg;
            if (valid_s1_reg) begin
                transparent_reg <= transp_s1_reg;
                red_reg         <= transp_s1_reg ? '0 : red_next;
                green_reg       <= transp_s1_reg ? '0 : green_next;
                blue_reg        <= transp_s1_reg ? '0 : blue_next;
            end
        end
    end

    assign bus.red         = red_reg;
    assign bus.green       = green_reg;
    assign bus.blue        = blue_reg;
    assign bus.transparent = transparent_reg;
    assign bus.out_valid   = out_valid_reg;
endmodule

// File: tb/tb_sprite_palette_bank.sv
// Self-checking bench for sprite_palette_bank: per-cycle model compare plus literal checks.
module tb_sprite_palette_bank;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sprite_palette_bank_if #(.INDEX_W(4), .NUM_PAL(4), .CH_W(4)) bus ();

    sprite_palette_bank #(.INDEX_W(4), .NUM_PAL(4), .CH_W(4), .TRANSP_IDX(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [11:0] m_mem [64];
    bit          m_s1v;
    int          m_s1a;
    bit          m_s1t;
    int          m_s1f;
    bit          m_v;
    logic [11:0] m_rgb;
    bit          m_t;
    bit          m_clr;
    int          m_ca;

    function automatic logic [11:0] faded(input logic [11:0] w, input int f);
        int ch [3];
        ch[0] = int'(w[11:8]);
        ch[1] = int'(w[7:4]);
        ch[2] = int'(w[3:0]);
        for (int k = 0; k < 3; k++) ch[k] = (ch[k] > f) ? ch[k] - f : 0;
        return {4'(ch[0]), 4'(ch[1]), 4'(ch[2])};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) m_mem[k] = 12'h000;
            m_s1v = 0; m_s1a = 0; m_s1t = 0; m_s1f = 0;
            m_v = 0; m_rgb = 12'h000; m_t = 0; m_clr = 0; m_ca = 0;
        end else begin
            // result of the read captured last cycle, against memory as it stood before this edge
            m_v = m_s1v;
            if (m_s1v) begin
                m_t   = m_s1t;
                m_rgb = m_s1t ? 12'h000 : faded(m_mem[m_s1a], m_s1f);
            end
            m_s1v = bus.pix_valid;
            if (bus.pix_valid) begin
                m_s1a = int'(bus.pal_sel) * 16 + int'(bus.index);
                m_s1t = (int'(bus.index) == 1);
`ifdef PALETTE_FADE_EN
                m_s1f = int'(bus.fade_lvl);
`else
                m_s1f = 0;
`endif
            end
            if (m_clr) begin
                m_mem[m_ca] = 12'h000;
                m_ca++;
                if (m_ca == 64) begin
                    m_clr = 0;
                    m_ca  = 0;
                end
            end else if (bus.clear_req) begin
                m_clr = 1;
                m_ca  = 0;
            end else if (bus.wr_valid) begin
                m_mem[int'(bus.wr_pal) * 16 + int'(bus.wr_idx)] = bus.wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_v));
            chk("mdl_rgb", 32'({bus.red, bus.green, bus.blue}), 32'(m_rgb));
            chk("mdl_transparent", 32'(bus.transparent), 32'(m_t));
            chk("mdl_clear_busy", 32'(bus.clear_busy), 32'(m_clr));
            chk("mdl_wr_ready", 32'(bus.wr_ready), 32'(!m_clr && !bus.clear_req));
        end
    end

    // out_valid run tracker for the back-to-back stream
    int cyc = 0;
    bit run_en = 0;
    int run_cnt, run_first, run_last;
    always @(negedge clk) begin
        cyc++;
        if (run_en && bus.out_valid) begin
            if (run_first < 0) run_first = cyc;
            run_last = cyc;
            run_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_entry(input int pal, input int idx, input logic [11:0] data);
        bus.wr_valid = 1'b1;
        bus.wr_pal   = 2'(pal);
        bus.wr_idx   = 4'(idx);
        bus.wr_data  = data;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_check(input string nm, input int pal, input int idx,
                              input logic [11:0] exp_rgb, input logic exp_t);
        bus.pix_valid = 1'b1;
        bus.pal_sel   = 2'(pal);
        bus.index     = 4'(idx);
        tick();
        bus.pix_valid = 1'b0;
        chk({nm, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_rgb"}, 32'({bus.red, bus.green, bus.blue}), 32'(exp_rgb));
        chk({nm, "_transp"}, 32'(bus.transparent), 32'(exp_t));
    endtask

    initial begin
        int cnt;
        bus.pix_valid = 0; bus.pal_sel = 0; bus.index = 0;
        bus.wr_valid = 0; bus.wr_pal = 0; bus.wr_idx = 0; bus.wr_data = 0;
        bus.clear_req = 0;
`ifdef PALETTE_FADE_EN
        bus.fade_lvl = 0;
`endif
        #1 rst_n = 1'b0;
        #20;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
        chk("rst_transp", 32'(bus.transparent), 32'd0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_clear_busy", 32'(bus.clear_busy), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        read_check("rd_p0i5", 0, 5, 12'h000, 1'b0);

        write_entry(2, 3, 12'hE43);
        read_check("rd_p2i3", 2, 3, 12'hE43, 1'b0);
        read_check("rd_p1i3", 1, 3, 12'h000, 1'b0);

        write_entry(0, 1, 12'hF0F);
        read_check("rd_transp", 0, 1, 12'h000, 1'b1);

        // distinct pattern in palette 3, then stream it back to back
        for (int i = 0; i < 16; i++) write_entry(3, i, {4'(i), 4'(15 - i), 4'(i ^ 5)});
        run_cnt = 0; run_first = -1; run_last = -1; run_en = 1;
        for (int i = 0; i < 16; i++) begin
            bus.pix_valid = 1'b1;
            bus.pal_sel   = 2'd3;
            bus.index     = 4'(i);
            tick();
        end
        bus.pix_valid = 1'b0;
        repeat (4) tick();
        run_en = 0;
        chk("stream_count", 32'(run_cnt), 32'd16);
        chk("stream_nogap", 32'(run_last - run_first), 32'd15);
        read_check("rd_p3i6", 3, 6, 12'h693, 1'b0);

        // clear with a competing write
        write_entry(3, 15, 12'hDED);
        read_check("rd_p3i15", 3, 15, 12'hDED, 1'b0);
        write_entry(2, 4, 12'h7C1);
        bus.clear_req = 1'b1;
        bus.wr_valid  = 1'b1;
        bus.wr_pal    = 2'd2;
        bus.wr_idx    = 4'd5;
        bus.wr_data   = 12'hABC;
        #1;
        chk("clr_wr_ready_same", 32'(bus.wr_ready), 32'd0);
        tick();
        bus.clear_req = 1'b0;
        bus.wr_valid  = 1'b0;
        cnt = 0;
        while (bus.clear_busy && cnt < 200) begin
            chk("clr_wr_ready_low", 32'(bus.wr_ready), 32'd0);
            bus.clear_req = (cnt == 10);
            cnt++;
            tick();
        end
        bus.clear_req = 1'b0;
        chk("clr_busy_cycles", 32'(cnt), 32'd64);
        chk("clr_ready_after", 32'(bus.wr_ready), 32'd1);
        read_check("rd_clr_p3i15", 3, 15, 12'h000, 1'b0);
        read_check("rd_clr_p2i4", 2, 4, 12'h000, 1'b0);

        // collision: stage-2 read of p1i7 coincides with a write to it
        write_entry(1, 7, 12'h16A);
        bus.pix_valid = 1'b1; bus.pal_sel = 2'd1; bus.index = 4'd7;
        tick();
        bus.wr_valid = 1'b1; bus.wr_pal = 2'd1; bus.wr_idx = 4'd7; bus.wr_data = 12'h8DA;
        tick();
        bus.wr_valid = 1'b0; bus.pix_valid = 1'b0;
        chk("coll_old", 32'({bus.red, bus.green, bus.blue}), 32'h16A);
        tick();
        chk("coll_new", 32'({bus.red, bus.green, bus.blue}), 32'h8DA);
        chk("coll_new_valid", 32'(bus.out_valid), 32'd1);

`ifdef PALETTE_FADE_EN
        write_entry(0, 2, 12'h4A8);
        bus.fade_lvl = 4'd5;
        read_check("fade", 0, 2, 12'h053, 1'b0);
        read_check("fade_transp", 0, 1, 12'h000, 1'b1);
        bus.fade_lvl = 4'd0;
`endif

        // asynchronous reset in the middle of a clear sweep
        write_entry(0, 9, 12'h5A5);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (5) tick();
        chk("midclr_busy", 32'(bus.clear_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.clear_busy), 32'd0);
        chk("midrst_ready", 32'(bus.wr_ready), 32'd1);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        read_check("rd_after_rst", 0, 9, 12'h000, 1'b0);
        read_check("rd_after_rst2", 1, 7, 12'h000, 1'b0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
